ram_wr_gen: RTL

Parametrised RAM port-A write pattern generator for dual-port RAM test and bring-up designs. On a start request it sweeps the write address across a configurable depth for a programmable number of passes, driving one of four data patterns. It raises a sticky read-enable flag for the port-B reader once a threshold address has been written, and signals completion with a done pulse.

---
 rtl/ram_wr_gen.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ram_wr_gen.sv
// ram_wr_gen: RAM port-A write pattern generator for dual-port RAM bring-up.
// Sweeps the write address over DEPTH words for a programmed number of passes,
// driving one of four data patterns, and raises a sticky flag telling the
// port-B reader that enough of the RAM has been written to start reading.
module ram_wr_gen #(
  parameter int          DATA_W = 8,
  parameter int          ADDR_W = 6,
  parameter int          DEPTH  = 64,
  parameter int          RD_TH  = 32,
  parameter logic [31:0] FILL   = 32'h0000_00A5,
  parameter logic [31:0] SEED   = 32'h0000_0001,
  parameter logic [31:0] POLY   = 32'h0000_00B8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [7:0]        pass_cnt,
  output logic              ram_wr_en,
  output logic              ram_wr_we,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              rd_flag,
  output logic              busy,
  output logic              done
);

  // Address of the final beat of a pass and of the beat that arms the reader.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] TH_ADDR   = ADDR_W'(RD_TH - 1);

  // Pattern constants narrowed to the data width.
  localparam logic [DATA_W-1:0] FILL_V = FILL[DATA_W-1:0];
  localparam logic [DATA_W-1:0] SEED_V = SEED[DATA_W-1:0];
  localparam logic [DATA_W-1:0] POLY_V = POLY[DATA_W-1:0];

  // Pattern selector encodings.
  localparam logic [1:0] MODE_ADDR = 2'd0;
  localparam logic [1:0] MODE_INV  = 2'd1;
  localparam logic [1:0] MODE_FILL = 2'd2;
  localparam logic [1:0] MODE_LFSR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [1:0]        mode_q;    // pattern latched at start
  logic [7:0]        pass_q;    // pass count latched at start, 0 = continuous
  logic [7:0]        rem_q;     // passes still to run, including the current one
  logic [DATA_W-1:0] lfsr;      // mode-3 pattern state

  logic last_beat;
  logic final_pass;

  // One Galois LFSR step: shift right, fold in POLY when a 1 falls out.
  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] v);
    return (v >> 1) ^ (v[0] ? POLY_V : '0);
  endfunction

  // Address zero-extended or truncated to the data width.
  function automatic logic [DATA_W-1:0] addr_to_data(input logic [ADDR_W-1:0] a);
    logic [ADDR_W+DATA_W-1:0] wide;
    wide = '0;
    wide[ADDR_W-1:0] = a;
    return wide[DATA_W-1:0];
  endfunction

  assign last_beat  = (ram_wr_addr == LAST_ADDR);
  // A latched count of 0 never reaches a final pass, so the sweep wraps forever.
  assign final_pass = (pass_q != 8'd0) && (rem_q == 8'd1);

  // Sequencer: run control, address sweep, pass counting, LFSR and reader flag.
  // NOTE: every register here is assigned with <= so all updates see the
  // pre-edge values; a blocking = would let later lines see half-updated state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      rd_flag     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mode_q      <= 2'd0;
      pass_q      <= 8'd0;
      rem_q       <= 8'd0;
      lfsr        <= SEED_V;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          // stop has priority over a simultaneous start.
          if (start && !stop) begin
            state       <= S_WRITE;
            ram_wr_en   <= 1'b1;
            ram_wr_addr <= '0;
            busy        <= 1'b1;
            rd_flag     <= 1'b0;
            mode_q      <= mode;
            pass_q      <= pass_cnt;
            rem_q       <= pass_cnt;
            lfsr        <= SEED_V;
          end
        end

        S_WRITE: begin
          // The beat on the bus this cycle always completes, even under stop.
          lfsr <= lfsr_step(lfsr);
          if (ram_wr_addr == TH_ADDR) begin
            rd_flag <= 1'b1;
          end

          if (stop) begin
            // Abort: back to idle with no completion pulse.
            state       <= S_IDLE;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            busy        <= 1'b0;
          end else if (last_beat && final_pass) begin
            // Last word of the last pass: announce completion.
            state       <= S_DONE;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            done        <= 1'b1;
          end else if (last_beat) begin
            // Wrap into the next pass without a gap.
            ram_wr_addr <= '0;
            if (pass_q != 8'd0) begin
              rem_q <= rem_q - 8'd1;
            end
          end else begin
            ram_wr_addr <= ram_wr_addr + 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state       <= S_IDLE;
          ram_wr_en   <= 1'b0;
          ram_wr_addr <= '0;
          busy        <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

  // Write data pattern, aligned with the registered address and forced to 0
  // whenever no beat is presented.
  // NOTE: the default assignment first keeps this block purely combinational;
  // leaving a path that skips ram_wr_data would infer a latch.
  always_comb begin
    ram_wr_data = '0;
    if (ram_wr_en) begin
      case (mode_q)
        MODE_ADDR: ram_wr_data = addr_to_data(ram_wr_addr);
        MODE_INV:  ram_wr_data = ~addr_to_data(ram_wr_addr);
        MODE_FILL: ram_wr_data = FILL_V;
        MODE_LFSR: ram_wr_data = lfsr;
        default:   ram_wr_data = '0;
      endcase
    end
  end

  // Port A is write-only, so the write strobe simply mirrors the enable.
  assign ram_wr_we = ram_wr_en;

endmodule
